// File: rtl/para_fetch_arbiter_pkg.sv
// Shared types and default sizes for the parallel-lane fetch arbiter.
package para_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_N_LANES = 4;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 8;

endpackage

// File: rtl/para_fetch_arbiter_if.sv
// Lane request/response and shared-RAM signals of the fetch arbiter.
interface para_fetch_arbiter_if #(
    parameter int N_LANES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
);

    logic [N_LANES-1:0]        req;
    logic [N_LANES*ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0]         ram_address;
    logic [DATA_W-1:0]         ram_dataout;
    logic [N_LANES-1:0]        grant;
    logic [N_LANES-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic [15:0]               served_count;

    // The arbiter drives the RAM address and the lane responses.
    modport master (
        input  req,
        input  req_addr,
        input  ram_dataout,
        output ram_address,
        output grant,
        output rsp_valid,
        output rsp_data,
        output busy,
        output served_count
    );

    modport slave (
        output req,
        output req_addr,
        output ram_dataout,
        input  ram_address,
        input  grant,
        input  rsp_valid,
        input  rsp_data,
        input  busy,
        input  served_count
    );

endinterface

// File: rtl/para_fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked requester at or after the pointer.
module rr_pick #(
    parameter int N_LANES = 4,
    parameter int PTR_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic [N_LANES-1:0] i_req,
    input  logic [N_LANES-1:0] i_mask,
    input  logic [PTR_W-1:0]   i_pointer,
    output logic [N_LANES-1:0] o_winner,
    output logic [PTR_W-1:0]   o_winnerIdx,
    output logic               o_anyValid
);

    logic [N_LANES-1:0] w_eligible;
    logic [PTR_W:0]     w_idx;

    assign w_eligible = i_req & ~i_mask;

    // Scan pointer, pointer+1, ... with wrap; the first eligible lane wins.
    always_comb begin
        o_winner    = '0;
        o_winnerIdx = '0;
        o_anyValid  = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_idx = {1'b0, i_pointer} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N_LANES)) begin
                w_idx = w_idx - (PTR_W+1)'(N_LANES);
            end
            if (!o_anyValid && w_eligible[w_idx[PTR_W-1:0]]) begin
                o_anyValid                  = 1'b1;
                o_winner[w_idx[PTR_W-1:0]]  = 1'b1;
                o_winnerIdx                 = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/para_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational-read program RAM among the processor lanes.
module para_fetch_arbiter
    import para_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic                clk,
    input logic                reset_n,
    para_fetch_arbiter_if.master bus
);

    localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    state_t             r_state;
    state_t             w_stateNext;
    logic [PTR_W-1:0]   r_pointer;
    logic [PTR_W-1:0]   r_winnerIdx;
    logic [N_LANES-1:0] r_grant;
    logic [N_LANES-1:0] r_rspValid;
    logic [DATA_W-1:0]  r_rspData;
    logic [ADDR_W-1:0]  r_ramAddress;
    logic [15:0]        r_servedCount;

    logic [N_LANES-1:0] w_winner;
    logic [PTR_W-1:0]   w_winnerIdx;
    logic               w_anyValid;
    logic [ADDR_W-1:0]  w_winnerAddr;
    logic               w_issue;
    logic               w_respond;

    // During RESP the lane being answered is masked so it cannot win twice in a row.
    rr_pick #(
        .N_LANES (N_LANES),
        .PTR_W   (PTR_W)
    ) u_rrPick (
        .i_req       (bus.req),
        .i_mask      (r_rspValid),
        .i_pointer   (r_pointer),
        .o_winner    (w_winner),
        .o_winnerIdx (w_winnerIdx),
        .o_anyValid  (w_anyValid)
    );

    always_comb begin
        w_winnerAddr = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (w_winner[i]) begin
                w_winnerAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_issue     = 1'b0;
        w_respond   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_stateNext = ISSUE;
                    w_issue     = 1'b1;
                end
            end
            ISSUE: begin
                w_stateNext = RESP;
                w_respond   = 1'b1;
            end
            RESP: begin
                if (w_anyValid) begin
                    w_stateNext = ISSUE;
                    w_issue     = 1'b1;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // The response, the count and the pointer advance together on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pointer     <= '0;
            r_winnerIdx   <= '0;
            r_grant       <= '0;
            r_rspValid    <= '0;
            r_rspData     <= '0;
            r_ramAddress  <= '0;
            r_servedCount <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_rspValid <= w_respond ? r_grant : '0;
            if (w_issue) begin
                r_grant      <= w_winner;
                r_winnerIdx  <= w_winnerIdx;
                r_ramAddress <= w_winnerAddr;
            end else if (w_respond) begin
                r_grant <= '0;
            end
            if (w_respond) begin
                r_rspData     <= bus.ram_dataout;
                r_servedCount <= r_servedCount + 16'd1;
                r_pointer     <= (r_winnerIdx == PTR_W'(N_LANES-1)) ? '0 : r_winnerIdx + 1'b1;
            end
        end
    end

    assign bus.ram_address  = r_ramAddress;
    assign bus.grant        = r_grant;
    assign bus.rsp_valid    = r_rspValid;
    assign bus.rsp_data     = r_rspData;
    assign bus.busy         = (r_state != IDLE);
    assign bus.served_count = r_servedCount;

endmodule

// File: tb/tb_para_fetch_arbiter.sv
// Scoreboard bench for para_fetch_arbiter: directed lane traffic against a RAM of addr[7:0]^5A.
module tb_para_fetch_arbiter;
    import para_pkg::*;

    localparam int NL = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    typedef struct {
        logic [NL-1:0] lane;
        logic [DW-1:0] data;
        logic [15:0]   count;
        int            gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    para_fetch_arbiter_if #(.N_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) bus();

    para_fetch_arbiter #(.N_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    assign bus.ram_dataout = bus.ram_address[7:0] ^ 8'h5A;

    always #5 clk = ~clk;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   rspSeen = 0;
    int   cycle = 0;
    int   lastRspCycle = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NL-1:0] reqV, input logic [NL*AW-1:0] addrs);
        bus.req      = reqV;
        bus.req_addr = addrs;
    endtask

    task automatic pushExp(input logic [NL-1:0] lane, input logic [DW-1:0] data,
                           input logic [15:0] count, input int gap);
        exp_t e;
        e.lane  = lane;
        e.data  = data;
        e.count = count;
        e.gap   = gap;
        expQ.push_back(e);
    endtask

    task automatic waitResponses(input int target, input int budget);
        int n = 0;
        while (rspSeen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rspSeen < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_timeout: got %0d responses, expected %0d", rspSeen, target);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (bus.rsp_valid != '0) begin
            rspSeen++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid %b, expected none", bus.rsp_valid);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp_lane", 32'(bus.rsp_valid), 32'(e.lane));
                checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                checkOutput("served_count", 32'(bus.served_count), 32'(e.count));
                if (e.gap != 0) begin
                    checkOutput("rsp_gap", 32'(cycle - lastRspCycle), 32'(e.gap));
                end
            end
            checkOutput("grant_rsp_overlap", 32'(bus.grant & bus.rsp_valid), 32'd0);
            lastRspCycle = cycle;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(4'b1111, {16'h0013, 16'h0012, 16'h0011, 16'h0010});
        reset_n = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("reset_grant", 32'(bus.grant), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("reset_ram_address", 32'(bus.ram_address), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_served_count", 32'(bus.served_count), 32'd0);

        // Fairness: all four lanes, one completion every 2 cycles in lane order.
        pushExp(4'b0001, 8'h4A, 16'd1, 0);
        pushExp(4'b0010, 8'h4B, 16'd2, 2);
        pushExp(4'b0100, 8'h48, 16'd3, 2);
        pushExp(4'b1000, 8'h49, 16'd4, 2);
        pushExp(4'b0001, 8'h4A, 16'd5, 2);
        pushExp(4'b0010, 8'h4B, 16'd6, 2);
        pushExp(4'b0100, 8'h48, 16'd7, 2);
        pushExp(4'b1000, 8'h49, 16'd8, 2);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first_grant", 32'(bus.grant), 32'h1);
        checkOutput("first_ram_address", 32'(bus.ram_address), 32'h0010);
        checkOutput("first_busy", 32'(bus.busy), 32'd1);
        waitResponses(8, 40);
        applyStimulus(4'b0000, '0);
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        // Single fetch on lane 2.
        pushExp(4'b0100, 8'h49, 16'd9, 0);
        applyStimulus(4'b0100, {16'h0000, 16'h0013, 16'h0000, 16'h0000});
        @(negedge clk);
        checkOutput("single_grant", 32'(bus.grant), 32'h4);
        checkOutput("single_ram_address", 32'(bus.ram_address), 32'h0013);
        waitResponses(9, 10);
        applyStimulus(4'b0000, '0);
        repeat (3) @(negedge clk);

        // Lane 1 alone: masked in its own RESP, so one fetch every 3 cycles.
        pushExp(4'b0010, 8'h7B, 16'd10, 0);
        pushExp(4'b0010, 8'h7B, 16'd11, 3);
        pushExp(4'b0010, 8'h7B, 16'd12, 3);
        applyStimulus(4'b0010, {16'h0000, 16'h0000, 16'h0021, 16'h0000});
        waitResponses(12, 30);
        pushExp(4'b1000, 8'h69, 16'd13, 2);
        pushExp(4'b0010, 8'h7B, 16'd14, 2);
        pushExp(4'b1000, 8'h69, 16'd15, 2);
        pushExp(4'b0010, 8'h7B, 16'd16, 2);
        applyStimulus(4'b1010, {16'h0033, 16'h0000, 16'h0021, 16'h0000});
        waitResponses(16, 20);
        applyStimulus(4'b0000, '0);
        repeat (3) @(negedge clk);

        // Lane 0 drops its request during ISSUE; the response must still arrive.
        pushExp(4'b0001, 8'h1A, 16'd17, 0);
        applyStimulus(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0040});
        @(negedge clk);
        checkOutput("drop_grant", 32'(bus.grant), 32'h1);
        applyStimulus(4'b0000, '0);
        waitResponses(17, 5);
        repeat (3) @(negedge clk);
        checkOutput("drop_busy", 32'(bus.busy), 32'd0);
        checkOutput("drop_queue_empty", 32'(expQ.size()), 32'd0);

        // Reset during ISSUE aborts the fetch.
        applyStimulus(4'b1000, {16'h0050, 16'h0000, 16'h0000, 16'h0000});
        @(negedge clk);
        checkOutput("midreset_grant", 32'(bus.grant), 32'h8);
        reset_n = 1'b0;
        applyStimulus(4'b0000, '0);
        @(negedge clk);
        checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midreset_grant_clr", 32'(bus.grant), 32'd0);
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_served_count", 32'(bus.served_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("postreset_busy", 32'(bus.busy), 32'd0);

        // Counter wrap from FFFF.
        force dut.r_servedCount = 16'hFFFF;
        @(negedge clk);
        release dut.r_servedCount;
        pushExp(4'b0100, 8'hFF, 16'h0000, 0);
        applyStimulus(4'b0100, {16'h0000, 16'h00A5, 16'h0000, 16'h0000});
        @(negedge clk);
        checkOutput("wrap_ram_address", 32'(bus.ram_address), 32'h00A5);
        waitResponses(18, 5);
        applyStimulus(4'b0000, '0);
        repeat (3) @(negedge clk);
        checkOutput("wrap_served_hold", 32'(bus.served_count), 32'h0000);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/para_fetch_arbiter.md
# para_fetch_arbiter

Round-robin arbiter sharing one combinational-read program RAM (8-bit data, 16-bit address) among the N parallel processor lanes of the parallel microprocessor. Each lane raises a fetch request with an address. The arbiter grants one lane at a time, drives the RAM address, captures the returned byte and returns it to that lane with a one-cycle valid pulse. It sits between the lane fetch logic and the single shared RAM instance.

## Interface
- `N_LANES`, 4: number of requesting lanes (≥2).
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 8: RAM data width.
- `clk` in, 1: single clock; all state updates on rising edge.
- `reset_n` in, 1: reset; one clock; reset is synchronous and active-low.
- `req` in, N_LANES: per-lane fetch request, level.
- `req_addr` in, N_LANES*ADDR_W: lane i address at bits [i*ADDR_W +: ADDR_W].
- `ram_address` out, ADDR_W: registered address to shared RAM.
- `ram_dataout` in, DATA_W: RAM combinational read data.
- `grant` out, N_LANES: registered one-hot; lane owning RAM during ISSUE.
- `rsp_valid` out, N_LANES: registered one-hot, one-cycle pulse; data for that lane.
- `rsp_data` out, DATA_W: registered fetched byte, valid with `rsp_valid`.
- `busy` out, 1: high in ISSUE and RESP.
- `served_count` out, 16: completed fetches; wraps FFFF→0000.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any `req`, pick winner by round robin. Load `ram_address` from the winner's `req_addr` and set `grant` one-hot, then go to ISSUE. Otherwise stay.
- ISSUE (exactly 1 cycle): capture `ram_dataout` into `rsp_data` and go to RESP. `req`/`req_addr` changes during ISSUE are ignored.
- RESP (exactly 1 cycle):
  - Drive `rsp_valid[winner]`=1 and clear `grant`.
  - Increment `served_count` and set pointer to (winner+1) mod N_LANES.
  - Re-arbitrate with the just-served lane masked. If another lane requests, go to ISSUE directly; else go to IDLE.
- Round robin: the highest-priority lane is the pointer. Scan pointer, pointer+1, … with wrap to 0.
- Handshake: a lane holds `req` and `req_addr` stable until its `rsp_valid`. Dropping `req` after grant does not cancel the transaction; the response is still produced.
- A lane keeping `req` high through its RESP cycle is a new request, eligible from the next IDLE or next arbitration.
- At most one bit of `grant` is set. At most one bit of `rsp_valid` is set. They are never set in the same cycle.

## Timing
- Reset (`reset_n`=0 at edge): state IDLE, pointer 0, `grant`=0, `rsp_valid`=0, `rsp_data`=0, `ram_address`=0, `busy`=0, `served_count`=0.
- Reset mid-ISSUE or mid-RESP aborts the transaction with no `rsp_valid` and no count increment.
- `req` sampled high in IDLE at edge t:
  - `grant`/`ram_address` valid from t+1.
  - `rsp_valid` high from t+2 for one cycle.
  - Latency is 2 cycles.
- Back-to-back (different lanes): one completion every 2 cycles; RESP→ISSUE with no IDLE gap.
- A single lane requesting continuously completes one fetch every 3 cycles (IDLE, ISSUE, RESP), because it is masked in its own RESP.
- `served_count` increments on the RESP edge.

## Structure
- Package `para_pkg`: FSM state enum (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), default `N_LANES`/`ADDR_W`/`DATA_W` constants.
- Sub-module `rr_pick`: combinational inputs (`req` vector, mask, pointer), outputs one-hot winner plus any-valid flag.
- Top: FSM, pointer register, output registers, `served_count`.

## Test plan
RAM model for all scenarios: `ram_dataout` = `ram_address`[7:0] ^ 8'h5A.
- **Reset values:** hold `reset_n`=0 two cycles with `req`=4'b1111 → all outputs 0 and `busy`=0. After release, lane 0 is granted first.
- **Single fetch:** lane 2 `req` with addr 16'h0013 at edge t → `grant`=4'b0100 and `ram_address`=0013 at t+1. At t+2, `rsp_valid`=4'b0100 with `rsp_data`=8'h49 and `served_count`=1.
- **Fairness:** all four lanes request continuously with addrs 0010,0011,0012,0013 → grant order 0,1,2,3,0,… and one `rsp_valid` every 2 cycles. `rsp_data` sequence is 4A,4B,48,49.
- **Mask/pointer:** only lane 1 requests continuously → `rsp_valid`[1] every 3 cycles. Add lane 3 mid-stream → they alternate.
- **Early drop:** lane 0 drops `req` during ISSUE → `rsp_valid`[0] still pulses next cycle with correct data.
- **Reset mid-op and wrap:** `reset_n`=0 during ISSUE → no `rsp_valid`, state IDLE. Separately, force `served_count` to FFFF, complete one fetch → `served_count`=0000.
